phase_seq: RTL and testbench

- Multi-cycle phase sequencer for the 16-bit SIMPLE core.
- Steps each instruction through IF, ID, EX, MEM and WB, and emits one enable per phase to the PC/IR, register file, ALU/shifter, data memory and write-back path.
- Handles the IN/OUT I/O handshake with a timeout, HLT detection, and the retired-instruction count.
- Sits between the IR and the registered decoder, gating when the decoder's outputs take effect.

---
 rtl/phase_seq.sv | 126 ++++++++++++
 tb/tb_phase_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_seq.sv
// Multi-cycle IF/ID/EX/MEM/WB phase sequencer for the 16-bit SIMPLE core.
// Moore enables per phase, IN/OUT handshake with timeout, HLT and retire count.
module phase_seq #(
    parameter int IO_TIMEOUT = 255,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      inst,
    input  logic             io_ack,
    output logic             pc_we,
    output logic             ir_we,
    output logic             dec_en,
    output logic             alu_en,
    output logic             mem_en,
    output logic             io_req,
    output logic             wb_en,
    output logic             halted,
    output logic             io_err,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(IO_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic               io_err_q, io_err_d;
    logic [CNT_W-1:0]   icount_q, icount_d;
    logic [15:0]        wait_q, wait_d;

    logic is_ls, is_io, is_hlt;

    assign is_ls  = ~inst[15];
    assign is_io  = (inst[15:14] == 2'b11) && ((inst[7:4] == 4'hC) || (inst[7:4] == 4'hD));
    assign is_hlt = (inst[15:14] == 2'b11) && (inst[7:4] == 4'hF);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            io_err_q <= 1'b0;
            icount_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            io_err_q <= io_err_d;
            icount_q <= icount_d;
            wait_q   <= wait_d;
        end
    end

    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        io_err_d = io_err_q;
        icount_d = icount_q;
        wait_d   = wait_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_IF;
                    io_err_d = 1'b0;
                end
            end
            S_IF: state_d = S_ID;
            S_ID: state_d = S_EX;
            S_EX: begin
                if (is_hlt) begin
                    state_d  = S_HALT;
                    icount_d = icount_q + 1'b1;
                end else begin
                    state_d = S_MEM;
                    wait_d  = '0;
                end
            end
            S_MEM: begin
                // An ack on the timeout edge wins: it is tested first.
                if (!is_io || io_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d  = S_WB;
                    io_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_WB: begin
                state_d  = S_IF;
                icount_d = icount_q + 1'b1;
            end
            S_HALT: begin
                if (start) begin
                    state_d  = S_IF;
                    io_err_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pc_we  = (state_q == S_IF);
    assign ir_we  = (state_q == S_IF);
    assign dec_en = (state_q == S_ID);
    assign alu_en = (state_q == S_EX);
    assign mem_en = (state_q == S_MEM) && is_ls;
    assign io_req = (state_q == S_MEM) && is_io;
    assign wb_en  = (state_q == S_WB);
    assign halted = (state_q == S_HALT);
    assign io_err = io_err_q;
    assign phase  = state_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_phase_seq.sv
// Bench for phase_seq: per-instruction latency table, transaction-level
// reference model under random stimulus, HLT, async reset and counter wrap.
module tb_phase_seq;

    localparam int T    = 4;
    localparam int CW   = 4;
    localparam int CMOD = 1 << CW;
    localparam int NV   = 11;

    logic          clk, rst_n, start, io_ack;
    logic [15:0]   inst;
    logic          pc_we, ir_we, dec_en, alu_en, mem_en, io_req, wb_en, halted, io_err;
    logic [2:0]    phase;
    logic [CW-1:0] icount;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    typedef struct {
        logic [15:0] inst;
        int          ack_at;
        int          cycles;
        int          mem_n;
        int          io_n;
        bit          err;
        bit          halt;
    } vec_t;

    vec_t vecs [NV];

    phase_seq #(.IO_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inst(inst), .io_ack(io_ack),
        .pc_we(pc_we), .ir_we(ir_we), .dec_en(dec_en), .alu_en(alu_en),
        .mem_en(mem_en), .io_req(io_req), .wb_en(wb_en), .halted(halted),
        .io_err(io_err), .phase(phase), .icount(icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit cls_io(input logic [15:0] v);
        return (v[15:14] == 2'b11) && (v[7:4] == 4'hC || v[7:4] == 4'hD);
    endfunction

    function automatic bit cls_hlt(input logic [15:0] v);
        return (v[15:14] == 2'b11) && (v[7:4] == 4'hF);
    endfunction

    // Enables the phase table demands: {pc,ir,dec,alu,mem,io,wb,halted,io_err}.
    function automatic logic [8:0] exp_en(input int ph, input logic [15:0] v, input bit err);
        return {ph == 1, ph == 1, ph == 2, ph == 3, ph == 4 && !v[15],
                ph == 4 && cls_io(v), ph == 5, ph == 6, err};
    endfunction

    task automatic expect_cycle(input string name, input int ph);
        logic [15:0] act, exp;
        act = {pc_we, ir_we, dec_en, alu_en, mem_en, io_req, wb_en, halted, io_err, phase, icount};
        exp = {exp_en(ph, inst, exp_err), 3'(ph), 4'(exp_cnt)};
        check(name, 32'(act), 32'(exp));
    endtask

    task automatic noise();
        start  = 1'($urandom_range(0, 1));
        io_ack = 1'($urandom_range(0, 1));
    endtask

    // Reference model: walks one instruction through its expected phase list.
    // Entry: the next falling edge shows IF. Exit: same condition again.
    task automatic run_model(input logic [15:0] v, input int ack_at);
        @(negedge clk); inst = v; expect_cycle("m_if", 1); noise();
        @(negedge clk); expect_cycle("m_id", 2); noise();
        @(negedge clk); expect_cycle("m_ex", 3); noise();
        if (cls_hlt(v)) begin
            exp_cnt = (exp_cnt + 1) % CMOD;
            @(negedge clk); expect_cycle("m_halt", 6);
            start = 1'b0; io_ack = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk); expect_cycle("m_halt_hold", 6);
            end
            start   = 1'b1;
            exp_err = 1'b0;
            return;
        end
        for (int k = 1; k <= T; k++) begin
            @(negedge clk); expect_cycle("m_mem", 4);
            start = 1'($urandom_range(0, 1));
            if (!cls_io(v)) begin
                io_ack = 1'($urandom_range(0, 1));
                break;
            end
            io_ack = (k == ack_at);
            if (k == ack_at) break;
            if (k == T) exp_err = 1'b1;
        end
        @(negedge clk); expect_cycle("m_wb", 5); noise();
        exp_cnt = (exp_cnt + 1) % CMOD;
    endtask

    // Observes the DUT from IF to WB (counted) or HALT (not counted).
    task automatic measure(input logic [15:0] v, input int ack_at,
                           output int cyc, output int mem_n, output int io_n);
        cyc = 0; mem_n = 0; io_n = 0;
        start = 1'b0; io_ack = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (n == 0) inst = v;
            if (phase == 3'd6) break;
            if (phase >= 3'd1 && phase <= 3'd5) cyc++;
            if (mem_en) mem_n++;
            if (io_req) io_n++;
            io_ack = io_req && (io_n == ack_at);
            if (phase == 3'd5) break;
        end
        io_ack = 1'b0;
    endtask

    initial begin
        int cyc, mem_n, io_n;
        logic [15:0] v;

        vecs[0]  = '{16'hC000, 0, 5, 0, 0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 0, 5, 1, 0, 1'b0, 1'b0};
        vecs[2]  = '{16'h4000, 0, 5, 1, 0, 1'b0, 1'b0};
        vecs[3]  = '{16'h8123, 0, 5, 0, 0, 1'b0, 1'b0};
        vecs[4]  = '{16'hC0E0, 0, 5, 0, 0, 1'b0, 1'b0};
        vecs[5]  = '{16'hC0C0, 3, 7, 0, 3, 1'b0, 1'b0};
        vecs[6]  = '{16'hC0D0, 1, 5, 0, 1, 1'b0, 1'b0};
        vecs[7]  = '{16'hC0C0, 4, 8, 0, 4, 1'b0, 1'b0};
        vecs[8]  = '{16'hC0D0, 0, 8, 0, 4, 1'b1, 1'b0};
        vecs[9]  = '{16'h3FFF, 0, 5, 1, 0, 1'b1, 1'b0};
        vecs[10] = '{16'hC0F0, 0, 3, 0, 0, 1'b1, 1'b1};

        rst_n = 1'b0; start = 1'b0; io_ack = 1'b0; inst = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        repeat (10) begin
            @(negedge clk); expect_cycle("idle", 0);
        end
        start = 1'b1;
        run_model(16'hC000, 0);

        for (int i = 0; i < NV; i++) begin
            measure(vecs[i].inst, vecs[i].ack_at, cyc, mem_n, io_n);
            if (vecs[i].halt) exp_cnt = (exp_cnt + 1) % CMOD;
            check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cycles));
            check($sformatf("v%0d_mem_en", i), 32'(mem_n), 32'(vecs[i].mem_n));
            check($sformatf("v%0d_io_req", i), 32'(io_n), 32'(vecs[i].io_n));
            check($sformatf("v%0d_io_err", i), 32'(io_err), 32'(vecs[i].err));
            check($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].halt));
            check($sformatf("v%0d_icount", i), 32'(icount), 32'(exp_cnt));
            if (!vecs[i].halt) exp_cnt = (exp_cnt + 1) % CMOD;
            exp_err = vecs[i].err;
        end

        // Sitting in HALT with io_err set; start must leave and clear it.
        repeat (2) begin
            @(negedge clk); expect_cycle("halt_stay", 6);
        end
        start = 1'b1; exp_err = 1'b0;
        @(negedge clk); inst = 16'hC0F0; expect_cycle("halt_restart", 1); start = 1'b1;
        @(negedge clk); expect_cycle("hlt_id", 2); start = 1'b0;
        @(negedge clk); expect_cycle("hlt_ex", 3); start = 1'b1;
        exp_cnt = (exp_cnt + 1) % CMOD;
        @(negedge clk); expect_cycle("hlt_enter", 6); start = 1'b0;
        @(negedge clk); expect_cycle("hlt_hold", 6); start = 1'b1;

        for (int i = 0; i < 60; i++) begin
            v = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1: begin v[15:14] = 2'b11; v[7:4] = 4'hC; end
                2, 3: begin v[15:14] = 2'b11; v[7:4] = 4'hD; end
                4:    begin v[15:14] = 2'b11; v[7:4] = 4'hF; end
                default: ;
            endcase
            run_model(v, int'($urandom_range(0, T + 1)));
        end

        // Async reset in the middle of an IN wait.
        @(negedge clk); inst = 16'hC0C0; start = 1'b0; io_ack = 1'b0; expect_cycle("r_if", 1);
        @(negedge clk); expect_cycle("r_id", 2);
        @(negedge clk); expect_cycle("r_ex", 3);
        @(negedge clk); expect_cycle("r_mem1", 4);
        @(negedge clk); expect_cycle("r_mem2", 4);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0; exp_err = 1'b0;
        expect_cycle("async_rst", 0);
        @(negedge clk); expect_cycle("rst_hold", 0);
        rst_n = 1'b1;
        @(negedge clk); expect_cycle("post_rst_idle", 0);
        start = 1'b1;

        for (int i = 0; i < CMOD; i++) begin
            v = 16'($urandom);
            v[15:14] = 2'($urandom_range(0, 2));
            run_model(v, 0);
        end
        @(negedge clk);
        check("icount_wrap", 32'(icount), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
